bp_fe_queue_roll_ctrl: RTL and testbench

//  Sequencing controller for the checkpointed (rolly) FE queue between FE and BE issue.

---
 rtl/bp_fe_queue_roll_ctrl.sv | 70 +++++++
 tb/tb_bp_fe_queue_roll_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/bp_fe_queue_roll_ctrl.sv
// bp_fe_queue_roll_ctrl: FE queue roll/clear/dequeue sequencer; optional strobe counters under BP_FE_QUEUE_ROLL_CTRL_PERF_EN
module bp_fe_queue_roll_ctrl #(
  parameter int fifo_els_p  = 8,
  parameter int fence_cyc_p = 2,
  parameter int cnt_width_p = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              read_i,
  input  logic                              commit_v_i,
  input  logic                              replay_v_i,
  input  logic                              redirect_v_i,
  output logic                              read_ready_o,
  output logic                              deq_v_o,
  output logic                              roll_v_o,
  output logic                              clr_v_o,
  output logic [$clog2(fifo_els_p+1)-1:0]   inflight_o,
  output logic                              busy_o,
`ifdef BP_FE_QUEUE_ROLL_CTRL_PERF_EN
  output logic [cnt_width_p-1:0]            roll_cnt_o,
  output logic [cnt_width_p-1:0]            clr_cnt_o,
`endif
  output logic                              err_o
);
  localparam int iw = $clog2(fifo_els_p+1);
  localparam int fw = fence_cyc_p > 0 ? $clog2(fence_cyc_p+1) : 1;
  localparam logic [1:0] run_s = 2'd0, roll_s = 2'd1, clear_s = 2'd2, fence_s = 2'd3;
  logic [1:0]    state, state_n;
  logic [fw-1:0] fcnt, fcnt_n;
  logic [iw-1:0] inflight_n;
  logic          acc_read, err_n;
  always_comb begin
    read_ready_o = (state == run_s) && (inflight_o != iw'(fifo_els_p));
    roll_v_o     = state == roll_s;
    clr_v_o      = state == clear_s;
    busy_o       = state != run_s;
    acc_read     = read_i & read_ready_o;
    deq_v_o      = commit_v_i & (inflight_o != '0);
    inflight_n   = roll_v_o ? '0 : inflight_o + iw'(acc_read) - iw'(deq_v_o);
    err_n        = err_o | (read_i & ~read_ready_o) | (commit_v_i & (inflight_o == '0));
    state_n      = (state == run_s)   ? (redirect_v_i ? clear_s : replay_v_i ? roll_s : run_s)
                 : (state == roll_s)  ? (redirect_v_i ? clear_s : run_s)
                 : (state == clear_s) ? ((fence_cyc_p > 0) ? fence_s : run_s)
                 : ((fcnt <= fw'(1)) ? run_s : fence_s);
    fcnt_n       = (state == clear_s) ? fw'(fence_cyc_p)
                 : (state == fence_s) ? fcnt - fw'(1) : fcnt;
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state      <= run_s;
      fcnt       <= '0;
      inflight_o <= '0;
      err_o      <= 1'b0;
    end else begin
      state      <= state_n;
      fcnt       <= fcnt_n;
      inflight_o <= inflight_n;
      err_o      <= err_n;
    end
`ifdef BP_FE_QUEUE_ROLL_CTRL_PERF_EN
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      roll_cnt_o <= '0;
      clr_cnt_o  <= '0;
    end else begin
      roll_cnt_o <= (roll_v_o && ~&roll_cnt_o) ? roll_cnt_o + cnt_width_p'(1) : roll_cnt_o;
      clr_cnt_o  <= (clr_v_o && ~&clr_cnt_o) ? clr_cnt_o + cnt_width_p'(1) : clr_cnt_o;
    end
`endif
endmodule

// File: tb/tb_bp_fe_queue_roll_ctrl.sv
// tb_bp_fe_queue_roll_ctrl: vector table, corner sequences and random run against a reference model
module tb_bp_fe_queue_roll_ctrl;
  localparam int els = 8;
  localparam int fence = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic read = 1'b0, commit_v = 1'b0, replay_v = 1'b0, redirect_v = 1'b0;
  logic read_ready, deq_v, roll_v, clr_v, busy, err;
  logic [3:0] inflight;
`ifdef BP_FE_QUEUE_ROLL_CTRL_PERF_EN
  logic [15:0] roll_cnt, clr_cnt;
`endif
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  bp_fe_queue_roll_ctrl #(.fifo_els_p(els), .fence_cyc_p(fence), .cnt_width_p(16)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .read_i(read), .commit_v_i(commit_v),
    .replay_v_i(replay_v), .redirect_v_i(redirect_v), .read_ready_o(read_ready),
    .deq_v_o(deq_v), .roll_v_o(roll_v), .clr_v_o(clr_v), .inflight_o(inflight),
    .busy_o(busy),
`ifdef BP_FE_QUEUE_ROLL_CTRL_PERF_EN
    .roll_cnt_o(roll_cnt), .clr_cnt_o(clr_cnt),
`endif
    .err_o(err));
  typedef struct {
    bit r, c, rp, rd;
    bit ready, deq, roll, clr, busy, err;
    int infl;
  } vec_t;
  vec_t tbl[18];
  int  m_infl, m_fence;
  bit  m_roll, m_clr, m_err;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(bit r, bit c, bit rp, bit rd);
    @(negedge clk);
    read = r; commit_v = c; replay_v = rp; redirect_v = rd;
    #2;
  endtask
  task automatic do_reset;
    @(negedge clk);
    read = 0; commit_v = 0; replay_v = 0; redirect_v = 0;
    reset_n = 0;
    #1;
    chk("rst_ready", read_ready, 1);
    chk("rst_strobes", {deq_v, roll_v, clr_v, busy, err}, 0);
    chk("rst_inflight", inflight, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    m_infl = 0; m_fence = 0; m_roll = 0; m_clr = 0; m_err = 0;
  endtask
  task automatic rand_cyc(bit r, bit c, bit rp, bit rd);
    bit idle, ready, deq;
    drive(r, c, rp, rd);
    idle  = !m_roll && !m_clr && m_fence == 0;
    ready = idle && m_infl < els;
    deq   = c && m_infl > 0;
    chk("rnd_ready", read_ready, ready);
    chk("rnd_deq", deq_v, deq);
    chk("rnd_roll_clr", {roll_v, clr_v}, {m_roll, m_clr});
    chk("rnd_busy", busy, !idle);
    chk("rnd_inflight", inflight, m_infl);
    chk("rnd_err", err, m_err);
    m_err   = m_err || (r && !ready) || (c && m_infl == 0);
    m_infl  = m_roll ? 0 : m_infl + int'(r && ready) - int'(deq);
    m_fence = m_clr ? fence : (m_fence > 0 ? m_fence - 1 : 0);
    m_clr   = (idle || m_roll) && rd;
    m_roll  = idle && rp && !rd;
  endtask
  initial begin
    //            r c rp rd  rdy deq roll clr busy err infl
    tbl[0]  = '{1,0,0,0, 1,0,0,0,0,0, 0};
    tbl[1]  = '{1,0,0,0, 1,0,0,0,0,0, 1};
    tbl[2]  = '{1,0,0,0, 1,0,0,0,0,0, 2};
    tbl[3]  = '{0,1,0,0, 1,1,0,0,0,0, 3};
    tbl[4]  = '{0,1,0,0, 1,1,0,0,0,0, 2};
    tbl[5]  = '{0,1,0,0, 1,1,0,0,0,0, 1};
    tbl[6]  = '{0,0,0,0, 1,0,0,0,0,0, 0};
    tbl[7]  = '{1,0,0,0, 1,0,0,0,0,0, 0};
    tbl[8]  = '{1,0,0,0, 1,0,0,0,0,0, 1};
    tbl[9]  = '{1,0,0,0, 1,0,0,0,0,0, 2};
    tbl[10] = '{0,0,1,0, 1,0,0,0,0,0, 3};
    tbl[11] = '{0,0,0,0, 0,0,1,0,1,0, 3};
    tbl[12] = '{0,0,0,0, 1,0,0,0,0,0, 0};
    tbl[13] = '{0,0,1,1, 1,0,0,0,0,0, 0};
    tbl[14] = '{0,0,0,0, 0,0,0,1,1,0, 0};
    tbl[15] = '{0,0,0,0, 0,0,0,0,1,0, 0};
    tbl[16] = '{0,0,0,0, 0,0,0,0,1,0, 0};
    tbl[17] = '{0,0,0,0, 1,0,0,0,0,0, 0};
    do_reset;
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].c, tbl[i].rp, tbl[i].rd);
      chk($sformatf("vec%0d_ready", i), read_ready, tbl[i].ready);
      chk($sformatf("vec%0d_deq", i), deq_v, tbl[i].deq);
      chk($sformatf("vec%0d_roll_clr", i), {roll_v, clr_v}, {tbl[i].roll, tbl[i].clr});
      chk($sformatf("vec%0d_busy_err", i), {busy, err}, {tbl[i].busy, tbl[i].err});
      chk($sformatf("vec%0d_inflight", i), inflight, tbl[i].infl);
    end
    // commit with nothing in flight, then fill to capacity
    do_reset;
    drive(0, 1, 0, 0);
    chk("empty_commit_deq", deq_v, 0);
    drive(0, 0, 0, 0);
    chk("empty_commit_err", err, 1);
    chk("empty_commit_inflight", inflight, 0);
    for (int i = 0; i < els; i++) drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    chk("full_ready", read_ready, 0);
    chk("full_inflight", inflight, els);
    drive(0, 0, 0, 0);
    chk("full_read_ignored", inflight, els);
    chk("err_sticky", err, 1);
    // async reset while a roll strobe is up
    do_reset;
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    chk("pre_reset_roll", roll_v, 1);
    reset_n = 0;
    #1;
    chk("mid_roll_reset_roll", roll_v, 0);
    chk("mid_roll_reset_inflight", inflight, 0);
    chk("mid_roll_reset_busy", busy, 0);
    @(negedge clk);
    reset_n = 1;
    // replay then redirect on consecutive cycles: roll followed by clear
    do_reset;
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 1);
    chk("roll_then_redirect_roll", roll_v, 1);
    drive(0, 0, 1, 0);
    chk("roll_then_redirect_clr", {roll_v, clr_v}, 2'b01);
    drive(0, 0, 0, 0);
    chk("fence_drops_replay", {roll_v, busy}, 2'b01);
`ifdef BP_FE_QUEUE_ROLL_CTRL_PERF_EN
    do_reset;
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);
    chk("perf_roll_cnt", roll_cnt, 2);
    chk("perf_clr_cnt", clr_cnt, 1);
`endif
    for (int k = 0; k < 4; k++) begin
      do_reset;
      for (int i = 0; i < 200; i++)
        rand_cyc($urandom_range(99) < 55, $urandom_range(99) < 40,
                 $urandom_range(99) < 6, $urandom_range(99) < 4);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
